// File: rtl/alu_issue_ctrl_pkg.sv
// Shared constants for the ALU issue controller: ALU op codes, op classes,
// FSM state encoding and the decoded-op bundle.
package alu_issue_ctrl_pkg;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_XOR = 4'd4;
    localparam logic [3:0] ALU_LUI = 4'd5;
    localparam logic [3:0] ALU_SR  = 4'd6;
    localparam logic [3:0] ALU_SL  = 4'd7;

    localparam logic [2:0] CLS_MEM = 3'd0;
    localparam logic [2:0] CLS_R   = 3'd1;
    localparam logic [2:0] CLS_I   = 3'd2;
    localparam logic [2:0] CLS_BR  = 3'd3;
    localparam logic [2:0] CLS_LUI = 3'd4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    typedef struct packed {
        logic [3:0] alu_op;
        logic       b_sel_imm;
        logic       a_zero;
        logic       is_branch;
        logic       br_neg;
        logic       illegal;
    } dec_t;

    // Shift ops only honour the low 5 bits of B.
    function automatic logic is_shift(input logic [3:0] op);
        return (op == ALU_SL) || (op == ALU_SR);
    endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Request/response handshake bundle between decode and the issue controller.
interface alu_issue_ctrl_if #(parameter int DATA_W = 32);
    logic              Req_Valid_i;
    logic              Req_Ready_o;
    logic [2:0]        Op_Class_i;
    logic [2:0]        Funct3_i;
    logic              Funct7b5_i;
    logic [DATA_W-1:0] Rs1_Data_i;
    logic [DATA_W-1:0] Rs2_Data_i;
    logic [DATA_W-1:0] Imm_i;
    logic              Rsp_Valid_o;
    logic              Rsp_Ready_i;
    logic [DATA_W-1:0] Rsp_Result_o;
    logic              Branch_Taken_o;
    logic              Illegal_o;

    modport master (
        output Req_Valid_i, Op_Class_i, Funct3_i, Funct7b5_i,
               Rs1_Data_i, Rs2_Data_i, Imm_i, Rsp_Ready_i,
        input  Req_Ready_o, Rsp_Valid_o, Rsp_Result_o, Branch_Taken_o, Illegal_o
    );

    modport slave (
        input  Req_Valid_i, Op_Class_i, Funct3_i, Funct7b5_i,
               Rs1_Data_i, Rs2_Data_i, Imm_i, Rsp_Ready_i,
        output Req_Ready_o, Rsp_Valid_o, Rsp_Result_o, Branch_Taken_o, Illegal_o
    );
endinterface

// File: rtl/alu_issue_ctrl_alu_op_decode.sv
// Combinational decode of {class, funct3, funct7[5]} into ALU control.
module alu_op_decode
    import alu_issue_ctrl_pkg::*;
(
    input  logic [2:0] i_class,
    input  logic [2:0] i_f3,
    input  logic       i_f7b5,
    output dec_t       o_dec
);

    // Illegal combinations fall back to ADD so the ALU sees a harmless op.
    always_comb begin
        o_dec = '{alu_op: ALU_ADD, b_sel_imm: 1'b0, a_zero: 1'b0,
                  is_branch: 1'b0, br_neg: 1'b0, illegal: 1'b0};
        case (i_class)
            CLS_MEM: o_dec.b_sel_imm = 1'b1;
            CLS_R, CLS_I: begin
                o_dec.b_sel_imm = (i_class == CLS_I);
                case (i_f3)
                    3'b000: o_dec.alu_op = (i_class == CLS_R && i_f7b5) ? ALU_SUB : ALU_ADD;
                    3'b100: o_dec.alu_op = ALU_XOR;
                    3'b110: o_dec.alu_op = ALU_OR;
                    3'b111: o_dec.alu_op = ALU_AND;
                    3'b001: o_dec.alu_op = ALU_SL;
                    3'b101: begin
                        if (i_f7b5) o_dec.illegal = 1'b1;
                        else        o_dec.alu_op  = ALU_SR;
                    end
                    default: o_dec.illegal = 1'b1;
                endcase
            end
            CLS_BR: begin
                if (i_f3 == 3'b000 || i_f3 == 3'b001) begin
                    o_dec.alu_op    = ALU_SUB;
                    o_dec.is_branch = 1'b1;
                    o_dec.br_neg    = i_f3[0];
                end else begin
                    o_dec.illegal = 1'b1;
                end
            end
            CLS_LUI: begin
                o_dec.alu_op    = ALU_LUI;
                o_dec.a_zero    = 1'b1;
                o_dec.b_sel_imm = 1'b1;
            end
            default: o_dec.illegal = 1'b1;
        endcase
        if (o_dec.illegal) begin
            o_dec.alu_op    = ALU_ADD;
            o_dec.b_sel_imm = 1'b0;
            o_dec.a_zero    = 1'b0;
        end
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// ALU issue controller: registers one decoded request, drives the ALU for one
// EXEC cycle, captures result/zero and holds the response until accepted.
// A request presented in cycle 0 gives EXEC in cycle 1 and a valid response in cycle 2.
module alu_issue_ctrl
    import alu_issue_ctrl_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    alu_issue_ctrl_if.slave   bus,
    output logic [3:0]        ALU_Operation_o,
    output logic [DATA_W-1:0] A_o,
    output logic [DATA_W-1:0] B_o,
    input  logic [DATA_W-1:0] ALU_Result_i,
    input  logic              Zero_i
);

    localparam logic [DATA_W-1:0] SHAMT_MASK = DATA_W'(5'h1f);

    logic [1:0]        r_state;
    logic [3:0]        r_op;
    logic [DATA_W-1:0] r_a, r_b;
    logic              r_is_br, r_br_neg, r_illegal;
    logic [DATA_W-1:0] r_rsp_result;
    logic              r_br_taken, r_rsp_illegal;

    dec_t              w_dec;
    logic [DATA_W-1:0] w_a, w_b_raw, w_b;
    logic              w_accept;

    alu_op_decode u_dec (
        .i_class (bus.Op_Class_i),
        .i_f3    (bus.Funct3_i),
        .i_f7b5  (bus.Funct7b5_i),
        .o_dec   (w_dec)
    );

    // Operand selection; illegal ops already forced to ADD in decode, zero both operands here.
    always_comb begin
        w_a     = (w_dec.a_zero || w_dec.illegal) ? '0 : bus.Rs1_Data_i;
        w_b_raw = w_dec.illegal ? '0 : (w_dec.b_sel_imm ? bus.Imm_i : bus.Rs2_Data_i);
        w_b     = is_shift(w_dec.alu_op) ? (w_b_raw & SHAMT_MASK) : w_b_raw;
    end

    assign w_accept = (r_state == ST_IDLE) && bus.Req_Valid_i;

    // FSM plus operand and response registers; reset drops any in-flight op.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_op          <= ALU_ADD;
            r_a           <= '0;
            r_b           <= '0;
            r_is_br       <= 1'b0;
            r_br_neg      <= 1'b0;
            r_illegal     <= 1'b0;
            r_rsp_result  <= '0;
            r_br_taken    <= 1'b0;
            r_rsp_illegal <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_op      <= w_dec.alu_op;
                        r_a       <= w_a;
                        r_b       <= w_b;
                        r_is_br   <= w_dec.is_branch;
                        r_br_neg  <= w_dec.br_neg;
                        r_illegal <= w_dec.illegal;
                        r_state   <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    r_rsp_result  <= r_illegal ? '0 : ALU_Result_i;
                    r_br_taken    <= r_is_br & (Zero_i ^ r_br_neg);
                    r_rsp_illegal <= r_illegal;
                    r_state       <= ST_RESP;
                end
                ST_RESP: begin
                    if (bus.Rsp_Ready_i) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign ALU_Operation_o    = r_op;
    assign A_o                = r_a;
    assign B_o                = r_b;
    assign bus.Req_Ready_o    = (r_state == ST_IDLE);
    assign bus.Rsp_Valid_o    = (r_state == ST_RESP);
    assign bus.Rsp_Result_o   = r_rsp_result;
    assign bus.Branch_Taken_o = r_br_taken;
    assign bus.Illegal_o      = r_rsp_illegal;

endmodule
